// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: parametrised single-clock 1RW + 1R SRAM model.
// After reset an init sweep writes INIT_VALUE to every word, then `ready`
// rises. Port 0 does masked writes or reads; port 1 only reads. A port 0
// write and a port 1 read to the same address raise `collision`.
// Optional macro SRAM_BYPASS_EN: a colliding port 1 read returns the merged
// (write-first) word instead of the old contents (read-first).
module sram_1rw1r_param #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WMASK_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              rstn,
  output logic                              ready,
  input  logic                              csb0,
  input  logic                              web0,
  input  logic [DATA_WIDTH/WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]             addr0,
  input  logic [DATA_WIDTH-1:0]             din0,
  output logic [DATA_WIDTH-1:0]             dout0,
  output logic                              rvalid0,
  input  logic                              csb1,
  input  logic [ADDR_WIDTH-1:0]             addr1,
  output logic [DATA_WIDTH-1:0]             dout1,
  output logic                              rvalid1,
  output logic                              collision
);

  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
  localparam int unsigned DEPTH      = 32'(1) << ADDR_WIDTH;

  // Lanes must tile the word exactly.
  generate
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_wmask
      $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
  endgenerate

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   dout0_q, dout0_d;
  logic [DATA_WIDTH-1:0]   dout1_q, dout1_d;
  logic                    rvalid0_q, rvalid0_d;
  logic                    rvalid1_q, rvalid1_d;
  logic                    collision_q, collision_d;

  logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];

  logic [DATA_WIDTH-1:0]   lane_bits;
  logic                    rd0, wr0, rd1;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_wa;
  logic [DATA_WIDTH-1:0]   mem_wd;
  logic [DATA_WIDTH-1:0]   mem_wbits;

  // Expand the per-lane write mask to a per-bit enable.
  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      lane_bits[i*WMASK_WIDTH +: WMASK_WIDTH] = {WMASK_WIDTH{wmask0[i]}};
    end
  end

  assign rd0 = !csb0 && web0;
  assign wr0 = !csb0 && !web0 && (|wmask0);
  assign rd1 = !csb1;

  // Next state: init sweep, then port servicing with collision detection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    dout0_d     = dout0_q;
    dout1_d     = dout1_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    collision_d = 1'b0;
    mem_we      = 1'b0;
    mem_wa      = addr0;
    mem_wd      = din0;
    mem_wbits   = lane_bits;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_wa    = cnt_q;
        mem_wd    = INIT_VALUE;
        mem_wbits = '1;
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        mem_we = wr0;
        if (rd0) begin
          dout0_d   = mem_q[addr0];
          rvalid0_d = 1'b1;
        end
        if (rd1) begin
          rvalid1_d   = 1'b1;
          collision_d = wr0 && (addr0 == addr1);
`ifdef SRAM_BYPASS_EN
          if (collision_d) begin
            dout1_d = (mem_q[addr1] & ~lane_bits) | (din0 & lane_bits);
          end else begin
            dout1_d = mem_q[addr1];
          end
`else
          dout1_d = mem_q[addr1];
`endif
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Control and output registers; array contents are not reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      dout0_q     <= '0;
      dout1_q     <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      collision_q <= collision_d;
    end
  end

  // Single bit-masked write port shared by the sweep and port 0.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= (mem_q[mem_wa] & ~mem_wbits) | (mem_wd & mem_wbits);
    end
  end

  assign ready     = ready_q;
  assign dout0     = dout0_q;
  assign dout1     = dout1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: default instance plus a 64x16 instance with
// 16-bit lanes. Expected read data is queued when a read is issued and
// popped when the matching rvalid is seen.
module tb_sram_1rw1r_param;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  logic        a_ready, a_csb0, a_web0, a_rvalid0, a_csb1, a_rvalid1, a_collision;
  logic [3:0]  a_wmask0;
  logic [7:0]  a_addr0, a_addr1;
  logic [31:0] a_din0, a_dout0, a_dout1;

  logic        b_ready, b_csb0, b_web0, b_rvalid0, b_csb1, b_rvalid1, b_collision;
  logic [3:0]  b_wmask0;
  logic [3:0]  b_addr0, b_addr1;
  logic [63:0] b_din0, b_dout0, b_dout1;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [63:0] qb [$];
  logic [31:0] exp32;
  logic [63:0] exp64;

  sram_1rw1r_param u_dut_a (
    .clk(clk), .rstn(rstn), .ready(a_ready),
    .csb0(a_csb0), .web0(a_web0), .wmask0(a_wmask0), .addr0(a_addr0), .din0(a_din0),
    .dout0(a_dout0), .rvalid0(a_rvalid0),
    .csb1(a_csb1), .addr1(a_addr1), .dout1(a_dout1), .rvalid1(a_rvalid1),
    .collision(a_collision)
  );

  sram_1rw1r_param #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .WMASK_WIDTH(16)) u_dut_b (
    .clk(clk), .rstn(rstn), .ready(b_ready),
    .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0), .addr0(b_addr0), .din0(b_din0),
    .dout0(b_dout0), .rvalid0(b_rvalid0),
    .csb1(b_csb1), .addr1(b_addr1), .dout1(b_dout1), .rvalid1(b_rvalid1),
    .collision(b_collision)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; one tick spans one rising edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    a_csb0 = 1'b1; a_web0 = 1'b1; a_wmask0 = '0; a_addr0 = '0; a_din0 = '0;
    a_csb1 = 1'b1; a_addr1 = '0;
    b_csb0 = 1'b1; b_web0 = 1'b1; b_wmask0 = '0; b_addr0 = '0; b_din0 = '0;
    b_csb1 = 1'b1; b_addr1 = '0;
  endtask

  task automatic a_write(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] m);
    a_csb0 = 1'b0; a_web0 = 1'b0; a_wmask0 = m; a_addr0 = ad; a_din0 = d;
    tick();
    a_csb0 = 1'b1; a_web0 = 1'b1; a_wmask0 = '0;
  endtask

  task automatic test_reset();
    int n;
    int nb;
    idle();
    #2 rstn = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", a_ready); end
    checks++; if (a_rvalid0 !== 1'b0) begin errors++; $display("FAIL reset_rvalid0 got %0b want 0", a_rvalid0); end
    checks++; if (a_rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid1 got %0b want 0", a_rvalid1); end
    checks++; if (a_collision !== 1'b0) begin errors++; $display("FAIL reset_collision got %0b want 0", a_collision); end
    checks++; if (a_dout0 !== 32'h0) begin errors++; $display("FAIL reset_dout0 got %h want 0", a_dout0); end
    checks++; if (a_dout1 !== 32'h0) begin errors++; $display("FAIL reset_dout1 got %h want 0", a_dout1); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready got %0b want 0", b_ready); end
    tick();
    tick();
    rstn = 1'b1;
    n  = 0;
    nb = -1;
    while (a_ready !== 1'b1 && n < 400) begin
      if (b_ready === 1'b1 && nb < 0) nb = n;
      if (n == 5) begin
        a_csb0 = 1'b0; a_web0 = 1'b0; a_wmask0 = 4'hF; a_addr0 = 8'h10; a_din0 = 32'hDEADBEEF;
      end else if (n == 6) begin
        a_csb0 = 1'b0; a_web0 = 1'b1; a_wmask0 = '0; a_addr0 = 8'h10;
        a_csb1 = 1'b0; a_addr1 = 8'h10;
      end else if (n == 7) begin
        idle();
        checks++; if (a_rvalid0 !== 1'b0) begin errors++; $display("FAIL init_rvalid0 got %0b want 0", a_rvalid0); end
        checks++; if (a_rvalid1 !== 1'b0) begin errors++; $display("FAIL init_rvalid1 got %0b want 0", a_rvalid1); end
      end
      tick();
      n++;
    end
    checks++; if (n != 256) begin errors++; $display("FAIL init_edges got %0d want 256", n); end
    checks++; if (nb != 16) begin errors++; $display("FAIL b_init_edges got %0d want 16", nb); end
  endtask

  task automatic test_idle_reads();
    logic [7:0] addrs [4];
    addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF; addrs[3] = 8'h10;
    for (int i = 0; i < 4; i++) begin
      a_csb1 = 1'b0; a_addr1 = addrs[i];
      q1.push_back(32'h0);
      tick();
      checks++;
      if (a_rvalid1 !== 1'b1) begin
        errors++; $display("FAIL idle_rvalid1 addr %h got %0b want 1", addrs[i], a_rvalid1);
        void'(q1.pop_front());
      end else begin
        exp32 = q1.pop_front();
        checks++;
        if (a_dout1 !== exp32) begin errors++; $display("FAIL idle_dout1 addr %h got %h want %h", addrs[i], a_dout1, exp32); end
      end
    end
    a_csb1 = 1'b1;
    tick();
    checks++; if (a_rvalid1 !== 1'b0) begin errors++; $display("FAIL idle_rvalid1_drop got %0b want 0", a_rvalid1); end
  endtask

  task automatic test_masked_write();
    a_write(8'h20, 32'h11223344, 4'hF);
    checks++; if (a_rvalid0 !== 1'b0) begin errors++; $display("FAIL wr_rvalid0 got %0b want 0", a_rvalid0); end
    a_write(8'h20, 32'hAABBCCDD, 4'h5);
    a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 8'h20;
    q0.push_back(32'h11BB33DD);
    tick();
    a_csb0 = 1'b1;
    checks++;
    if (a_rvalid0 !== 1'b1) begin
      errors++; $display("FAIL mask_rvalid0 got %0b want 1", a_rvalid0);
      void'(q0.pop_front());
    end else begin
      exp32 = q0.pop_front();
      checks++;
      if (a_dout0 !== exp32) begin errors++; $display("FAIL mask_dout0 got %h want %h", a_dout0, exp32); end
    end
    tick();
    checks++; if (a_rvalid0 !== 1'b0) begin errors++; $display("FAIL mask_rvalid0_pulse got %0b want 0", a_rvalid0); end
    checks++; if (a_dout0 !== 32'h11BB33DD) begin errors++; $display("FAIL dout0_hold got %h want 11bb33dd", a_dout0); end
    a_write(8'h20, 32'h00000000, 4'h0);
    checks++; if (a_dout0 !== 32'h11BB33DD) begin errors++; $display("FAIL wr_dout0_hold got %h want 11bb33dd", a_dout0); end
    a_csb1 = 1'b0; a_addr1 = 8'h20;
    q1.push_back(32'h11BB33DD);
    tick();
    a_csb1 = 1'b1;
    checks++;
    if (a_rvalid1 !== 1'b1) begin
      errors++; $display("FAIL zmask_rvalid1 got %0b want 1", a_rvalid1);
      void'(q1.pop_front());
    end else begin
      exp32 = q1.pop_front();
      checks++;
      if (a_dout1 !== exp32) begin errors++; $display("FAIL zmask_dout1 got %h want %h", a_dout1, exp32); end
    end
  endtask

  task automatic test_collision();
    a_write(8'h30, 32'h01020304, 4'hF);
    // Same edge: masked write and port 1 read of 0x30.
    a_csb0 = 1'b0; a_web0 = 1'b0; a_wmask0 = 4'h3; a_addr0 = 8'h30; a_din0 = 32'hFFFFFFFF;
    a_csb1 = 1'b0; a_addr1 = 8'h30;
`ifdef SRAM_BYPASS_EN
    q1.push_back(32'h0102FFFF);
`else
    q1.push_back(32'h01020304);
`endif
    tick();
    idle();
    checks++; if (a_collision !== 1'b1) begin errors++; $display("FAIL coll_flag got %0b want 1", a_collision); end
    checks++;
    if (a_rvalid1 !== 1'b1) begin
      errors++; $display("FAIL coll_rvalid1 got %0b want 1", a_rvalid1);
      void'(q1.pop_front());
    end else begin
      exp32 = q1.pop_front();
      checks++;
      if (a_dout1 !== exp32) begin errors++; $display("FAIL coll_dout1 got %h want %h", a_dout1, exp32); end
    end
    // Follow-up read sees the completed write.
    a_csb1 = 1'b0; a_addr1 = 8'h30;
    q1.push_back(32'h0102FFFF);
    tick();
    idle();
    checks++; if (a_collision !== 1'b0) begin errors++; $display("FAIL coll_clear got %0b want 0", a_collision); end
    exp32 = q1.pop_front();
    checks++; if (a_dout1 !== exp32 || a_rvalid1 !== 1'b1) begin errors++; $display("FAIL coll_after got %h/%0b want %h/1", a_dout1, a_rvalid1, exp32); end
    // Dual read of one address is not a collision.
    a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 8'h30;
    a_csb1 = 1'b0; a_addr1 = 8'h30;
    q0.push_back(32'h0102FFFF);
    q1.push_back(32'h0102FFFF);
    tick();
    idle();
    checks++; if (a_collision !== 1'b0) begin errors++; $display("FAIL dual_coll got %0b want 0", a_collision); end
    exp32 = q0.pop_front();
    checks++; if (a_dout0 !== exp32 || a_rvalid0 !== 1'b1) begin errors++; $display("FAIL dual_dout0 got %h/%0b want %h/1", a_dout0, a_rvalid0, exp32); end
    exp32 = q1.pop_front();
    checks++; if (a_dout1 !== exp32 || a_rvalid1 !== 1'b1) begin errors++; $display("FAIL dual_dout1 got %h/%0b want %h/1", a_dout1, a_rvalid1, exp32); end
    // Zero-mask write to the read address does not collide.
    a_csb0 = 1'b0; a_web0 = 1'b0; a_wmask0 = 4'h0; a_addr0 = 8'h30; a_din0 = 32'h0;
    a_csb1 = 1'b0; a_addr1 = 8'h30;
    q1.push_back(32'h0102FFFF);
    tick();
    idle();
    checks++; if (a_collision !== 1'b0) begin errors++; $display("FAIL zmask_coll got %0b want 0", a_collision); end
    exp32 = q1.pop_front();
    checks++; if (a_dout1 !== exp32) begin errors++; $display("FAIL zmask_coll_dout1 got %h want %h", a_dout1, exp32); end
    // Write to a different address does not collide.
    a_csb0 = 1'b0; a_web0 = 1'b0; a_wmask0 = 4'hF; a_addr0 = 8'h31; a_din0 = 32'h12345678;
    a_csb1 = 1'b0; a_addr1 = 8'h30;
    q1.push_back(32'h0102FFFF);
    tick();
    idle();
    checks++; if (a_collision !== 1'b0) begin errors++; $display("FAIL diff_addr_coll got %0b want 0", a_collision); end
    exp32 = q1.pop_front();
    checks++; if (a_dout1 !== exp32) begin errors++; $display("FAIL diff_addr_dout1 got %h want %h", a_dout1, exp32); end
  endtask

  task automatic test_reset_mid();
    int n;
    a_write(8'h40, 32'h00000055, 4'hF);
    a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 8'h40;
    q0.push_back(32'h00000055);
    tick();
    idle();
    exp32 = q0.pop_front();
    checks++; if (a_dout0 !== exp32 || a_rvalid0 !== 1'b1) begin errors++; $display("FAIL pre_rst_read got %h/%0b want %h/1", a_dout0, a_rvalid0, exp32); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (a_dout0 !== 32'h0) begin errors++; $display("FAIL mid_rst_dout0 got %h want 0", a_dout0); end
    checks++; if (a_dout1 !== 32'h0) begin errors++; $display("FAIL mid_rst_dout1 got %h want 0", a_dout1); end
    checks++; if (a_rvalid0 !== 1'b0) begin errors++; $display("FAIL mid_rst_rvalid0 got %0b want 0", a_rvalid0); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %0b want 0", a_ready); end
    #1 rstn = 1'b1;
    n = 0;
    while (a_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++; if (n != 256) begin errors++; $display("FAIL mid_rst_edges got %0d want 256", n); end
    a_csb1 = 1'b0; a_addr1 = 8'h40;
    q1.push_back(32'h0);
    tick();
    idle();
    exp32 = q1.pop_front();
    checks++; if (a_dout1 !== exp32 || a_rvalid1 !== 1'b1) begin errors++; $display("FAIL mid_rst_reread got %h/%0b want %h/1", a_dout1, a_rvalid1, exp32); end
  endtask

  task automatic test_param();
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b_ready got %0b want 1", b_ready); end
    b_csb0 = 1'b0; b_web0 = 1'b0; b_wmask0 = 4'b1000; b_addr0 = 4'hF; b_din0 = '1;
    tick();
    idle();
    b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = 4'hF;
    b_csb1 = 1'b0; b_addr1 = 4'h0;
    qb.push_back(64'hFFFF000000000000);
    qb.push_back(64'h0);
    tick();
    idle();
    exp64 = qb.pop_front();
    checks++; if (b_dout0 !== exp64 || b_rvalid0 !== 1'b1) begin errors++; $display("FAIL b_dout0 got %h/%0b want %h/1", b_dout0, b_rvalid0, exp64); end
    exp64 = qb.pop_front();
    checks++; if (b_dout1 !== exp64 || b_rvalid1 !== 1'b1) begin errors++; $display("FAIL b_dout1 got %h/%0b want %h/1", b_dout1, b_rvalid1, exp64); end
    b_csb1 = 1'b0; b_addr1 = 4'hF;
    qb.push_back(64'hFFFF000000000000);
    tick();
    idle();
    exp64 = qb.pop_front();
    checks++; if (b_dout1 !== exp64 || b_rvalid1 !== 1'b1) begin errors++; $display("FAIL b_dout1_f got %h/%0b want %h/1", b_dout1, b_rvalid1, exp64); end
  endtask

  initial begin
    test_reset();
    test_idle_reads();
    test_masked_write();
    test_collision();
    test_reset_mid();
    test_param();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_1rw1r_param.md
# sram_1rw1r_param

Parametrised single-clock 1RW+1R SRAM model for core and cache macro slots; the next generation of the fixed 32x256 OpenRAM behavioural model. Adds configurable width, depth and write-mask granularity, a post-reset clearing sweep with a `ready` indication, per-port read-valid strobes, and same-address write/read collision detection. Optional write-to-read forwarding is compiled in by macro. Fully synchronous, synthesizable RTL; no `#` delays.

## Interface
- `DATA_WIDTH`, 32: word width in bits.
- `ADDR_WIDTH`, 8: address width; depth is `1 << ADDR_WIDTH`.
- `WMASK_WIDTH`, 8: bits per write-mask lane; `NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH` (derived localparam).
- `INIT_VALUE`, 0: word value written to every address by the init sweep.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `rstn` in 1: asynchronous active-low reset.
- `ready` out 1: array initialised, requests accepted.
- `csb0` in 1: port 0 active-low select.
- `web0` in 1: port 0 active-low write enable.
- `wmask0` in NUM_WMASKS: per-lane write enable; bit i covers `[i*WMASK_WIDTH +: WMASK_WIDTH]`.
- `addr0` in ADDR_WIDTH: port 0 address.
- `din0` in DATA_WIDTH: port 0 write data.
- `dout0` out DATA_WIDTH: port 0 read data.
- `rvalid0` out 1: `dout0` updated this cycle.
- `csb1` in 1: port 1 active-low select.
- `addr1` in ADDR_WIDTH: port 1 address.
- `dout1` out DATA_WIDTH: port 1 read data.
- `rvalid1` out 1: `dout1` updated this cycle.
- `collision` out 1: port 0 write and port 1 read hit the same address on the previous edge.

## Operation
- FSM states: INIT, READY.
- Reset (async, `rstn`=0): state INIT, sweep counter 0. `ready`, `rvalid0`, `rvalid1` and `collision` are 0. `dout0` and `dout1` are 0. Array contents are not reset directly.
- INIT: each posedge writes `INIT_VALUE` to `mem[counter]` and increments the counter. After writing address DEPTH-1 the FSM goes to READY. `ready`=1 from that edge on, i.e. DEPTH edges after reset release.
- All port requests are ignored while `ready`=0: no write, no `rvalid`, `dout` unchanged.
- Port 0 write (`!csb0 && !web0`): only lanes with `wmask0[i]`=1 are updated. `dout0` holds its value and `rvalid0`=0. A write with `wmask0`=0 is a no-op.
- Port 0 read (`!csb0 && web0`): `dout0 <= mem[addr0]`, and `rvalid0`=1 for one cycle.
- Port 1 read (`!csb1`): `dout1 <= mem[addr1]`, and `rvalid1`=1 for one cycle.
- Deselected port: its `dout` holds the last read value (no X output) and its `rvalid` is 0.
- Collision: a port 0 write with nonzero mask, a port 1 read and `addr0==addr1` on the same edge set `collision`=1 for one cycle. The write always completes. `dout1` content depends on the Configuration macro.
- A port 0 read and a port 1 read to the same address is not a collision; both return the same stored word.
- Addresses cover the full `1<<ADDR_WIDTH` range. No out-of-range case exists and the sweep counter does not wrap.
- Elaboration error if `DATA_WIDTH % WMASK_WIDTH != 0`.

## Timing
- Read latency is 1: a request sampled at edge N gives `dout` and `rvalid` valid after edge N, readable until edge N+1.
- Write visibility: data written at edge N is returned by a read sampled at edge N+1 or later.
- Reset mid-operation (INIT or READY): outputs go to their reset values immediately and the sweep restarts at address 0. Array contents written before reset are overwritten by the sweep.
- `collision` is registered and aligns with `rvalid1` of the colliding read.

## Configuration
- `SRAM_BYPASS_EN` defined: on a collision, `dout1` returns the merged word. Masked lanes come from `din0`; unmasked lanes come from the old `mem` contents (write-first).
- Not defined: on a collision, `dout1` returns the old `mem` contents (read-first).
- `collision` flags identically in both builds.

## Test plan
- Reset then idle: `ready`=0 for 256 edges (defaults), then 1. Read port 1 at addrs 0x00, 0x7F, 0xFF -> `dout1`=0x00000000, and `rvalid1` pulses once per read.
- Request during INIT: write 0xDEADBEEF to 0x10 at cycle 5 after reset. After `ready`, read 0x10 -> 0x00000000.
- Masked write: write 0x11223344 to 0x20 (mask 0xF), then 0xAABBCCDD with mask 0x5. Read port 0 -> 0x11BB33DD, `rvalid0` high exactly one cycle.
- Collision: mem[0x30]=0x01020304. Same edge: write 0xFFFFFFFF with mask 0x3 via port 0, read 0x30 via port 1. Expect `collision`=1 and `dout1`=0x0102FFFF with `SRAM_BYPASS_EN`, 0x01020304 without. Next-cycle read -> 0x0102FFFF in both builds.
- Reset mid-READY: write 0x55 to 0x40, then pulse `rstn` low between edges. Outputs go to 0 immediately, `ready` returns after 256 edges, and a read of 0x40 -> 0x00000000.
- Parametrisation: DATA_WIDTH=64, ADDR_WIDTH=4, WMASK_WIDTH=16. Init takes 16 edges. Mask 0b1000 write of all-ones to 0xF, then read -> 0xFFFF000000000000.
